// File: rtl/arb2_1_pkg.sv
// Shared types and constants for the two-requester mux-path arbiter.
package arb2_1_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      OWN_A = 2'd1,
      OWN_B = 2'd2
   } arb_state_e;

   localparam logic SEL_A = 1'b0;
   localparam logic SEL_B = 1'b1;

   // last_owner encoding; reset value LAST_B lets A win the first tie
   localparam logic LAST_A = 1'b0;
   localparam logic LAST_B = 1'b1;

   localparam int unsigned MAX_HOLD_DEFAULT = 8;

endpackage

// File: rtl/arb2_1_hold_counter.sv
// hold_counter: 8-bit cycle counter with synchronous clear, enable and saturation at MAX.
module hold_counter #(
   parameter int unsigned MAX = 8
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_clear,
   input  logic       i_enable,
   output logic [7:0] o_count
);

   localparam logic [7:0] LIMIT = 8'(MAX);

   logic [7:0] r_count;

   // clear wins over enable; counting stops once LIMIT is reached
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= 8'd0;
      end else if (i_clear) begin
         r_count <= 8'd0;
      end else if (i_enable && (r_count < LIMIT)) begin
         r_count <= r_count + 8'd1;
      end else begin
         r_count <= r_count;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/arb2_1.sv
// arb2_1: two-requester arbiter for a shared mux input path with fair tie-breaking.
// Define ARB2_1_TIMEOUT_EN to force a handoff after MAX_HOLD grant cycles when the other side waits.
module arb2_1
   import arb2_1_pkg::*;
#(
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEFAULT
) (
   input  logic clk,
   input  logic reset_n,
   input  logic req_a,
   input  logic req_b,
   input  logic done_a,
   input  logic done_b,
   output logic gnt_a,
   output logic gnt_b,
   output logic sel,
   output logic busy,
   output logic timeout
);

   arb_state_e r_state;
   arb_state_e w_next;
   logic       r_gnt_a;
   logic       r_gnt_b;
   logic       r_sel;
   logic       r_last_owner;
   logic       r_timeout;
   logic       w_force;
   logic       w_hold_last;
   logic       w_enter_a;
   logic       w_enter_b;

`ifdef ARB2_1_TIMEOUT_EN
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   logic [7:0] w_hold_cnt;

   hold_counter #(
      .MAX (MAX_HOLD)
   ) u_hold_counter (
      .i_clk    (clk),
      .i_rst_n  (reset_n),
      .i_clear  (w_enter_a | w_enter_b),
      .i_enable (r_state != IDLE),
      .o_count  (w_hold_cnt)
   );

   assign w_hold_last = (w_hold_cnt == HOLD_LAST);
`else
   assign w_hold_last = 1'b0;
`endif

   // next-state: release beats forced handoff; a release hands over directly when the other side waits
   always_comb begin
      w_next  = r_state;
      w_force = 1'b0;
      case (r_state)
         IDLE: begin
            if (req_a && req_b) begin
               w_next = (r_last_owner == LAST_B) ? OWN_A : OWN_B;
            end else if (req_a) begin
               w_next = OWN_A;
            end else if (req_b) begin
               w_next = OWN_B;
            end else begin
               w_next = IDLE;
            end
         end
         OWN_A: begin
            if (done_a || !req_a) begin
               w_next = req_b ? OWN_B : IDLE;
            end else if (w_hold_last && req_b) begin
               w_next  = OWN_B;
               w_force = 1'b1;
            end else begin
               w_next = OWN_A;
            end
         end
         OWN_B: begin
            if (done_b || !req_b) begin
               w_next = req_a ? OWN_A : IDLE;
            end else if (w_hold_last && req_a) begin
               w_next  = OWN_A;
               w_force = 1'b1;
            end else begin
               w_next = OWN_B;
            end
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   assign w_enter_a = (w_next == OWN_A) && (r_state != OWN_A);
   assign w_enter_b = (w_next == OWN_B) && (r_state != OWN_B);

   // state and grant registers; grants are decoded from the next state so outputs come straight from flops
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= IDLE;
         r_gnt_a   <= 1'b0;
         r_gnt_b   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state   <= w_next;
         r_gnt_a   <= (w_next == OWN_A);
         r_gnt_b   <= (w_next == OWN_B);
         r_timeout <= w_force;
      end
   end

   // select and last owner move only on entry to an ownership state, so sel holds through IDLE
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sel        <= SEL_A;
         r_last_owner <= LAST_B;
      end else if (w_enter_a) begin
         r_sel        <= SEL_A;
         r_last_owner <= LAST_A;
      end else if (w_enter_b) begin
         r_sel        <= SEL_B;
         r_last_owner <= LAST_B;
      end else begin
         r_sel        <= r_sel;
         r_last_owner <= r_last_owner;
      end
   end

   assign gnt_a   = r_gnt_a;
   assign gnt_b   = r_gnt_b;
   assign sel     = r_sel;
   assign busy    = r_gnt_a | r_gnt_b;
   assign timeout = r_timeout;

endmodule

// File: tb/tb_arb2_1.sv
// Scoreboard bench for arb2_1: directed scenarios plus randomized traffic against an ownership model.
module tb_arb2_1;

`ifdef ARB2_1_TIMEOUT_EN
   localparam bit TMO = 1'b1;
`else
   localparam bit TMO = 1'b0;
`endif
   localparam int MAXH = 4;

   logic clk = 1'b0;
   logic reset_n, req_a, req_b, done_a, done_b;
   logic gnt_a, gnt_b, sel, busy, timeout;

   arb2_1 #(.MAX_HOLD(MAXH)) dut (
      .clk(clk), .reset_n(reset_n), .req_a(req_a), .req_b(req_b),
      .done_a(done_a), .done_b(done_b), .gnt_a(gnt_a), .gnt_b(gnt_b),
      .sel(sel), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct packed {logic ga; logic gb; logic sl; logic tm;} exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   // model: owner 0=none 1=A 2=B; cycles = grant cycles of current owner so far
   int owner;
   bit m_last_b;
   bit m_sel;
   bit m_tmo;
   int m_cycles;

   function automatic void chk(string name, logic act, logic req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s actual=%0b required=%0b t=%0t", name, act, req, $time);
      end
   endfunction

   function automatic void model_reset();
      owner = 0; m_last_b = 1'b1; m_sel = 1'b0; m_tmo = 1'b0; m_cycles = 0;
   endfunction

   function automatic void model_step();
      int nxt = owner;
      bit t = 1'b0;
      if (owner == 0) begin
         if (req_a && req_b) nxt = m_last_b ? 1 : 2;
         else if (req_a)     nxt = 1;
         else if (req_b)     nxt = 2;
      end else if (owner == 1) begin
         if (done_a || !req_a) nxt = req_b ? 2 : 0;
         else if (TMO && m_cycles == MAXH && req_b) begin nxt = 2; t = 1'b1; end
      end else begin
         if (done_b || !req_b) nxt = req_a ? 1 : 0;
         else if (TMO && m_cycles == MAXH && req_a) begin nxt = 1; t = 1'b1; end
      end
      if (nxt != 0 && nxt != owner) begin
         m_cycles = 1; m_last_b = (nxt == 2); m_sel = (nxt == 2);
      end else if (nxt != 0) begin
         m_cycles++;
      end
      owner = nxt;
      m_tmo = t;
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      e.ga = (owner == 1); e.gb = (owner == 2); e.sl = m_sel; e.tm = m_tmo;
      return e;
   endfunction

   task automatic cycle(input logic ra, input logic rb, input logic da, input logic db);
      req_a = ra; req_b = rb; done_a = da; done_b = db;
      @(posedge clk);
      if (reset_n) model_step();
      exp_q.push_back(model_out());
      #1;
   endtask

   // assert reset between edges and check the outputs drop before any clock edge
   task automatic async_reset(input int hold);
      @(negedge clk);
      #1;
      reset_n = 1'b0;
      model_reset();
      #1;
      chk("rst_gnt_a", gnt_a, 1'b0);
      chk("rst_gnt_b", gnt_b, 1'b0);
      chk("rst_sel", sel, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_timeout", timeout, 1'b0);
      repeat (hold) cycle(req_a, req_b, 1'b0, 1'b0);
      reset_n = 1'b1;
   endtask

   // monitor: one scoreboard entry per falling edge, plus structural invariants
   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("gnt_a", gnt_a, e.ga);
         chk("gnt_b", gnt_b, e.gb);
         chk("sel", sel, e.sl);
         chk("timeout", timeout, e.tm);
         chk("busy", busy, e.ga | e.gb);
      end
      chk("mutex", gnt_a & gnt_b, 1'b0);
   end

   initial begin
      reset_n = 1'b0; req_a = 1'b0; req_b = 1'b0; done_a = 1'b0; done_b = 1'b0;
      model_reset();
      #2;
      chk("init_gnt_a", gnt_a, 1'b0);
      chk("init_sel", sel, 1'b0);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;

      // single requester A, then drop
      cycle(1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // tie after reset goes to A, then alternating done pulses
      async_reset(1);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         cycle(1'b1, 1'b1, 1'b0, 1'b0);
         cycle(1'b1, 1'b1, (k % 2) == 0, (k % 2) == 1);
      end
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // A regranted repeatedly; done_b pulses while A owns are ignored
      for (int k = 0; k < 3; k++) begin
         cycle(1'b1, 1'b0, 1'b0, 1'b0);
         cycle(1'b1, 1'b0, 1'b0, 1'b1);
         cycle(1'b1, 1'b0, 1'b1, 1'b0);
      end
      cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // A held while B waits: forced handoff only when enabled
      cycle(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (10) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 1'b1, 1'b1);
      repeat (2) cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // A saturates alone, then B arrives late
      repeat (8) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      repeat (4) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // reset while B owns, then tie goes to A
      repeat (3) cycle(1'b0, 1'b1, 1'b0, 1'b0);
      async_reset(2);
      repeat (3) cycle(1'b1, 1'b1, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b0);

      // randomized traffic with sticky requests and sparse done pulses
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 199) == 0) begin
            async_reset(int'($urandom_range(1, 2)));
         end else begin
            cycle($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0);
         end
      end

      @(negedge clk);
      #1;
      chk("sb_drain", exp_q.size() == 0, 1'b1);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
